// File: rtl/lfo_scheduler.sv
// Shared 8-bit triangle LFO datapath time-multiplexed over CHANNELS voices, one channel per CK after SYNC.
// Optional per-channel restart input KEYON is enabled by defining LFO_KEYON_EN.
module lfo_scheduler #(
  parameter int CHANNELS = 8,
  parameter int RATE_W   = 8
) (
  input  logic                CK,
  input  logic                nRES,
  input  logic                SYNC,
  input  logic                nWR,
  input  logic [3:0]          ADDR,
  input  logic [7:0]          PIN_DB_IN,
`ifdef LFO_KEYON_EN
  input  logic [CHANNELS-1:0] KEYON,
`endif
  output logic                LFO_VLD,
  output logic [2:0]          LFO_CH,
  output logic [7:0]          LFO_VAL,
  output logic                BUSY,
  output logic                OVERRUN
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [7:0]        value [CHANNELS];
  logic [CHANNELS-1:0] dir;
  logic [RATE_W-1:0] presc [CHANNELS];
  logic [7:0]        limit [CHANNELS];
  logic [RATE_W-1:0] rate  [CHANNELS];

  logic [7:0]        nxt_val;
  logic              nxt_dir;
  logic [RATE_W-1:0] nxt_presc;
  logic [2:0]        wr_ch;
  logic              wr_ok;

  // Direction is decided first, then the value moves one step along it.
  function automatic logic [8:0] lfo_step(input logic [7:0] v, input logic d,
                                          input logic [7:0] lim);
    logic nd;
    nd = d;
    if (v >= lim)
      nd = 1'b1;
    else if (v == 8'd0)
      nd = 1'b0;
    return {nd, (nd ? v - 8'd1 : v + 8'd1)};
  endfunction

  assign BUSY  = (state == SCAN);
  assign wr_ch = ADDR[3:1];
  assign wr_ok = !nWR && (32'(wr_ch) < CHANNELS);

  always_comb begin
    nxt_val   = value[ptr];
    nxt_dir   = dir[ptr];
    nxt_presc = presc[ptr];
`ifdef LFO_KEYON_EN
    if (KEYON[ptr]) begin
      nxt_val   = '0;
      nxt_dir   = 1'b0;
      nxt_presc = '0;
    end else
`endif
    if (limit[ptr] == 8'd0) begin
      nxt_val   = '0;
      nxt_dir   = 1'b0;
      nxt_presc = '0;
    end else if (presc[ptr] == rate[ptr]) begin
      nxt_presc          = '0;
      {nxt_dir, nxt_val} = lfo_step(value[ptr], dir[ptr], limit[ptr]);
    end else begin
      nxt_presc = presc[ptr] + 1'b1;
    end
  end

  // Channel state and config; a write racing the update lands after it.
  always_ff @(posedge CK or negedge nRES) begin
    if (!nRES) begin
      dir <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        value[i] <= '0;
        presc[i] <= '0;
        limit[i] <= '0;
        rate[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (state == SCAN && ptr == 3'(i)) begin
          value[i] <= nxt_val;
          dir[i]   <= nxt_dir;
          presc[i] <= nxt_presc;
        end
        if (wr_ok && wr_ch == 3'(i)) begin
          if (ADDR[0])
            rate[i] <= RATE_W'(PIN_DB_IN);
          else
            limit[i] <= PIN_DB_IN;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge nRES) begin
    if (!nRES) begin
      state   <= IDLE;
      ptr     <= '0;
      LFO_VLD <= 1'b0;
      LFO_CH  <= '0;
      LFO_VAL <= '0;
      OVERRUN <= 1'b0;
    end else begin
      LFO_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (SYNC) begin
            state <= SCAN;
            ptr   <= '0;
          end
        end
        SCAN: begin
          LFO_VLD <= 1'b1;
          LFO_CH  <= ptr;
          LFO_VAL <= nxt_val;
          if (SYNC)
            OVERRUN <= 1'b1;
          if (ptr == 3'(CHANNELS - 1))
            state <= IDLE;
          else
            ptr <= ptr + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfo_scheduler.sv
// Directed bench for lfo_scheduler: scan timing, triangle sequences, prescaler, limit change, overrun, reset.
module tb_lfo_scheduler;

  logic       CK = 1'b0;
  logic       nRES = 1'b1;
  logic       SYNC = 1'b0;
  logic       nWR = 1'b1;
  logic [3:0] ADDR = 4'd0;
  logic [7:0] PIN_DB_IN = 8'd0;
  logic       LFO_VLD;
  logic [2:0] LFO_CH;
  logic [7:0] LFO_VAL;
  logic       BUSY;
  logic       OVERRUN;

  int checks = 0;
  int failures = 0;
  logic [7:0] got_val [8];

  lfo_scheduler #(.CHANNELS(8), .RATE_W(8)) dut (
    .CK(CK), .nRES(nRES), .SYNC(SYNC), .nWR(nWR), .ADDR(ADDR), .PIN_DB_IN(PIN_DB_IN),
    .LFO_VLD(LFO_VLD), .LFO_CH(LFO_CH), .LFO_VAL(LFO_VAL), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CK = ~CK;

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input int ch, input logic sel, input logic [7:0] d);
    ADDR = {3'(ch), sel};
    PIN_DB_IN = d;
    nWR = 1'b0;
    tick;
    nWR = 1'b1;
  endtask

  // sync_at >= 0 re-pulses SYNC on the edge that processes that channel
  task automatic scan(input int sync_at);
    SYNC = 1'b1;
    tick;
    SYNC = 1'b0;
    check("busy_start", BUSY, 1);
    check("vld_sync_edge", LFO_VLD, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == sync_at) SYNC = 1'b1;
      tick;
      SYNC = 1'b0;
      check("vld_slot", LFO_VLD, 1);
      check("ch_slot", LFO_CH, k);
      got_val[k] = LFO_VAL;
    end
    tick;
    check("vld_after", LFO_VLD, 0);
    check("busy_after", BUSY, 0);
    check("ch_hold", LFO_CH, 7);
  endtask

  int exp_tri [10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
  int exp_rate [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 1};
  int exp_lim [14] = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4};

  initial begin
    #2 nRES = 1'b0;
    tick;
    tick;
    check("rst_vld", LFO_VLD, 0);
    check("rst_ch", LFO_CH, 0);
    check("rst_val", LFO_VAL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_overrun", OVERRUN, 0);
    nRES = 1'b1;
    tick;

    // all config zero: every slot outputs 0
    scan(-1);
    for (int k = 0; k < 8; k++) check("zero_cfg_val", got_val[k], 0);
    check("no_overrun", OVERRUN, 0);

    // ch0 LIMIT=3 RATE=0
    write_reg(0, 1'b0, 8'd3);
    for (int i = 0; i < 10; i++) begin
      scan(-1);
      check("ch0_tri", got_val[0], exp_tri[i]);
    end
    check("ch3_off", got_val[3], 0);

    // ch2 LIMIT=2 RATE=2
    write_reg(2, 1'b0, 8'd2);
    write_reg(2, 1'b1, 8'd2);
    for (int i = 0; i < 9; i++) begin
      scan(-1);
      check("ch2_rate", got_val[2], exp_rate[i]);
    end

    // ch1 LIMIT=10 up to 8, then LIMIT=5
    write_reg(1, 1'b0, 8'd10);
    for (int i = 0; i < 8; i++) begin
      scan(-1);
      check("ch1_rise", got_val[1], i + 1);
    end
    write_reg(1, 1'b0, 8'd5);
    for (int i = 0; i < 14; i++) begin
      scan(-1);
      check("ch1_newlim", got_val[1], exp_lim[i]);
    end

    // SYNC during scan: no restart, sticky OVERRUN
    check("overrun_before", OVERRUN, 0);
    scan(3);
    check("overrun_set", OVERRUN, 1);
    tick;
    tick;
    tick;
    check("overrun_sticky", OVERRUN, 1);
    scan(-1);
    check("overrun_still", OVERRUN, 1);

    // async reset in cycle 3 of a scan
    SYNC = 1'b1;
    tick;
    SYNC = 1'b0;
    tick;
    tick;
    tick;
    check("midscan_vld", LFO_VLD, 1);
    #2 nRES = 1'b0;
    #1;
    check("async_vld", LFO_VLD, 0);
    check("async_ch", LFO_CH, 0);
    check("async_val", LFO_VAL, 0);
    check("async_busy", BUSY, 0);
    check("async_overrun", OVERRUN, 0);
    tick;
    nRES = 1'b1;
    tick;
    check("post_rst_vld", LFO_VLD, 0);
    scan(-1);
    for (int k = 0; k < 8; k++) check("post_rst_val", got_val[k], 0);
    check("post_rst_overrun", OVERRUN, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
